// File: rtl/toy_forward_buffer_pkg.sv
// rtl/toy_forward_buffer_pkg.sv - shared constants and entry type for the write-back forwarding buffer
package toy_pack;

    localparam int EU_NUM      = 2;
    localparam int REG_WIDTH   = 32;
    localparam int PREG_IDX_W  = 7;
    localparam int FWD_DEPTH   = 3;
    localparam int RD_PORT_NUM = 4;

    typedef struct packed {
        logic                  valid;
        logic [PREG_IDX_W-1:0] preg;
        logic [REG_WIDTH-1:0]  data;
    } fwd_entry_t;

    // preg 0 is the hardwired zero register and never produces a live entry
    function automatic logic preg_live(input logic en, input logic [PREG_IDX_W-1:0] preg);
        return en && (preg != '0);
    endfunction

endpackage

// File: rtl/toy_forward_buffer_if.sv
// rtl/toy_forward_buffer_if.sv - write-back / lookup bundle between the wb stage and the forwarding buffer
interface toy_forward_buffer_if;
    import toy_pack::*;

    logic                                    flush;
    logic [EU_NUM-1:0]                       v_wr_en;
    logic [EU_NUM-1:0][PREG_IDX_W-1:0]       v_wr_preg;
    logic [EU_NUM-1:0][REG_WIDTH-1:0]        v_wr_reg_data;
    logic [RD_PORT_NUM-1:0]                  v_rd_en;
    logic [RD_PORT_NUM-1:0][PREG_IDX_W-1:0]  v_rd_preg;
    logic [RD_PORT_NUM-1:0]                  v_rd_hit;
    logic [RD_PORT_NUM-1:0][REG_WIDTH-1:0]   v_rd_data;
    logic [EU_NUM-1:0][REG_WIDTH-1:0]        v_forward_data;

    modport master (
        output flush, v_wr_en, v_wr_preg, v_wr_reg_data, v_rd_en, v_rd_preg,
        input  v_rd_hit, v_rd_data, v_forward_data
    );

    modport slave (
        input  flush, v_wr_en, v_wr_preg, v_wr_reg_data, v_rd_en, v_rd_preg,
        output v_rd_hit, v_rd_data, v_forward_data
    );

endinterface

// File: rtl/toy_forward_buffer_match.sv
// rtl/toy_forward_buffer_match.sv - toy_forward_match: priority tag match over a flat entry vector (index 0 wins)
module toy_forward_match
    import toy_pack::*;
#(
    parameter int ENTRY_NUM = 1
) (
    input  logic                            rd_en,
    input  logic [PREG_IDX_W-1:0]           rd_preg,
    input  fwd_entry_t [ENTRY_NUM-1:0]      entries,
    output logic                            rd_hit,
    output logic [REG_WIDTH-1:0]            rd_data
);

    // Scan from lowest priority upward so the last match assigned is the winner
    always_comb begin
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (rd_en && (rd_preg != '0) && entries[i].valid && (entries[i].preg == rd_preg)) begin
                rd_hit  = 1'b1;
                rd_data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/toy_forward_buffer.sv
// rtl/toy_forward_buffer.sv - multi-stage write-back forwarding buffer; TOY_FWD_SAME_CYCLE_EN adds a same-cycle wr->rd path
module toy_forward_buffer
    import toy_pack::*;
(
    input  logic                 clk,
    input  logic                 rst,
    toy_forward_buffer_if.slave  bus
);

`ifdef TOY_FWD_SAME_CYCLE_EN
    localparam int LIVE_STAGES = FWD_DEPTH + 1;
`else
    localparam int LIVE_STAGES = FWD_DEPTH;
`endif
    localparam int ENTRY_NUM = LIVE_STAGES * EU_NUM;
    localparam int HIST_BASE = (LIVE_STAGES - FWD_DEPTH) * EU_NUM;

    fwd_entry_t [FWD_DEPTH-1:0][EU_NUM-1:0] stage_q;
    fwd_entry_t [EU_NUM-1:0]                wr_entry;
    fwd_entry_t [ENTRY_NUM-1:0]             flat;
    logic [EU_NUM-1:0][REG_WIDTH-1:0]       forward_q;
    logic [RD_PORT_NUM-1:0]                 rd_hit;
    logic [RD_PORT_NUM-1:0][REG_WIDTH-1:0]  rd_data;
    logic                                   dup_wr;

    always_comb begin
        for (int i = 0; i < EU_NUM; i++) begin
            wr_entry[i].valid = preg_live(bus.v_wr_en[i], bus.v_wr_preg[i]);
            wr_entry[i].preg  = bus.v_wr_preg[i];
            wr_entry[i].data  = bus.v_wr_reg_data[i];
        end
    end

    // Unconditional shift; flush drops both history and the incoming write
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q   <= '0;
            forward_q <= '0;
        end else begin
            forward_q <= bus.v_wr_reg_data;
            if (bus.flush) begin
                stage_q <= '0;
            end else begin
                stage_q[0] <= wr_entry;
                for (int k = 1; k < FWD_DEPTH; k++) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end
        end
    end

    // Youngest first, lowest lane first within a stage
    always_comb begin
        flat = '0;
`ifdef TOY_FWD_SAME_CYCLE_EN
        for (int i = 0; i < EU_NUM; i++) begin
            flat[i] = wr_entry[i];
        end
`endif
        for (int k = 0; k < FWD_DEPTH; k++) begin
            for (int i = 0; i < EU_NUM; i++) begin
                flat[HIST_BASE + k*EU_NUM + i] = stage_q[k][i];
            end
        end
    end

    for (genvar p = 0; p < RD_PORT_NUM; p++) begin : g_rd
        toy_forward_match #(
            .ENTRY_NUM (ENTRY_NUM)
        ) u_match (
            .rd_en   (bus.v_rd_en[p]),
            .rd_preg (bus.v_rd_preg[p]),
            .entries (flat),
            .rd_hit  (rd_hit[p]),
            .rd_data (rd_data[p])
        );
    end

    assign bus.v_rd_hit       = rd_hit;
    assign bus.v_rd_data      = rd_data;
    assign bus.v_forward_data = forward_q;

    always_comb begin
        dup_wr = 1'b0;
        for (int i = 0; i < EU_NUM; i++) begin
            for (int j = i + 1; j < EU_NUM; j++) begin
                if (wr_entry[i].valid && wr_entry[j].valid && (wr_entry[i].preg == wr_entry[j].preg)) begin
                    dup_wr = 1'b1;
                end
            end
        end
    end

    a_no_dup_wr: assert property (@(posedge clk) disable iff (rst) !dup_wr);

endmodule

// File: tb/tb_toy_forward_buffer.sv
// tb/tb_toy_forward_buffer.sv - scoreboard bench for toy_forward_buffer (both TOY_FWD_SAME_CYCLE_EN settings)
module tb_toy_forward_buffer;
    import toy_pack::*;

`ifdef TOY_FWD_SAME_CYCLE_EN
    localparam bit SC = 1'b1;
`else
    localparam bit SC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    toy_forward_buffer_if bus ();

    toy_forward_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic                   m_valid [FWD_DEPTH][EU_NUM];
    logic [PREG_IDX_W-1:0]  m_preg  [FWD_DEPTH][EU_NUM];
    logic [REG_WIDTH-1:0]   m_data  [FWD_DEPTH][EU_NUM];
    logic [EU_NUM-1:0][REG_WIDTH-1:0] m_fwd;

    typedef struct {
        logic                             hit  [RD_PORT_NUM];
        logic [REG_WIDTH-1:0]             data [RD_PORT_NUM];
        logic [EU_NUM-1:0][REG_WIDTH-1:0] fwd;
    } exp_t;

    exp_t sb[$];

    logic                 s_hit  [RD_PORT_NUM];
    logic [REG_WIDTH-1:0] s_data [RD_PORT_NUM];

    task automatic model_clear();
        for (int k = 0; k < FWD_DEPTH; k++)
            for (int i = 0; i < EU_NUM; i++) begin
                m_valid[k][i] = 1'b0;
                m_preg[k][i]  = '0;
                m_data[k][i]  = '0;
            end
    endtask

    // Candidate with smallest age wins, then smallest lane; age 0 is the live input
    task automatic model_lookup(input logic en, input logic [PREG_IDX_W-1:0] tag,
                                output logic hit, output logic [REG_WIDTH-1:0] data);
        int best_age = 1000;
        int best_eu  = 1000;
        hit  = 1'b0;
        data = '0;
        if (!en || tag == '0) return;
        for (int i = 0; i < EU_NUM; i++) begin
            if (SC && bus.v_wr_en[i] && bus.v_wr_preg[i] == tag &&
                (0 < best_age || (0 == best_age && i < best_eu))) begin
                best_age = 0; best_eu = i; hit = 1'b1; data = bus.v_wr_reg_data[i];
            end
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (m_valid[k][i] && m_preg[k][i] == tag &&
                    (k + 1 < best_age || (k + 1 == best_age && i < best_eu))) begin
                    best_age = k + 1; best_eu = i; hit = 1'b1; data = m_data[k][i];
                end
            end
        end
    endtask

    task automatic do_cycle();
        exp_t e;
        exp_t g;
        for (int p = 0; p < RD_PORT_NUM; p++)
            model_lookup(bus.v_rd_en[p], bus.v_rd_preg[p], e.hit[p], e.data[p]);
        e.fwd = m_fwd;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        for (int p = 0; p < RD_PORT_NUM; p++) begin
            s_hit[p]  = bus.v_rd_hit[p];
            s_data[p] = bus.v_rd_data[p];
            check($sformatf("hit%0d", p), 64'(s_hit[p]), 64'(g.hit[p]));
            check($sformatf("data%0d", p), 64'(s_data[p]), 64'(g.data[p]));
        end
        check("fwd", 64'(bus.v_forward_data), 64'(g.fwd));
        @(posedge clk);
        if (rst) begin
            model_clear();
            m_fwd = '0;
        end else begin
            m_fwd = bus.v_wr_reg_data;
            if (bus.flush) begin
                model_clear();
            end else begin
                for (int k = FWD_DEPTH - 1; k >= 1; k--)
                    for (int i = 0; i < EU_NUM; i++) begin
                        m_valid[k][i] = m_valid[k-1][i];
                        m_preg[k][i]  = m_preg[k-1][i];
                        m_data[k][i]  = m_data[k-1][i];
                    end
                for (int i = 0; i < EU_NUM; i++) begin
                    m_valid[0][i] = bus.v_wr_en[i] && (bus.v_wr_preg[i] != '0);
                    m_preg[0][i]  = bus.v_wr_preg[i];
                    m_data[0][i]  = bus.v_wr_reg_data[i];
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.flush         = 1'b0;
        bus.v_wr_en       = '0;
        bus.v_wr_preg     = '0;
        bus.v_wr_reg_data = '0;
        bus.v_rd_en       = '0;
        bus.v_rd_preg     = '0;
    endtask

    task automatic wr(input int eu, input int preg, input logic [REG_WIDTH-1:0] data);
        bus.v_wr_en[eu]       = 1'b1;
        bus.v_wr_preg[eu]     = PREG_IDX_W'(preg);
        bus.v_wr_reg_data[eu] = data;
    endtask

    task automatic rd(input int p, input int preg);
        bus.v_rd_en[p]   = 1'b1;
        bus.v_rd_preg[p] = PREG_IDX_W'(preg);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        m_fwd = '0;
        rst = 1'b0;

        for (int p = 0; p < RD_PORT_NUM; p++) rd(p, p + 1);
        do_cycle();
        for (int p = 0; p < RD_PORT_NUM; p++) check("rst_hit", 64'(s_hit[p]), 64'd0);

        // Visibility window
        idle(); wr(0, 5, 32'hA5); rd(0, 5);
        do_cycle();
        check("same_cycle_hit", 64'(s_hit[0]), 64'(SC));
        idle(); rd(0, 5);
        for (int n = 0; n < 3; n++) begin
            do_cycle();
            check("window_hit", 64'(s_hit[0]), 64'd1);
            check("window_data", 64'(s_data[0]), 64'hA5);
        end
        do_cycle();
        check("expired_hit", 64'(s_hit[0]), 64'd0);

        // Youngest wins
        idle(); wr(0, 9, 32'h11); do_cycle();
        idle(); wr(1, 9, 32'h22); do_cycle();
        idle(); rd(2, 9); do_cycle();
        check("youngest_data", 64'(s_data[2]), 64'h22);

        // preg 0 never captured
        idle(); wr(1, 0, 32'hFF); rd(1, 0); do_cycle();
        check("preg0_same", 64'(s_hit[1]), 64'd0);
        idle(); rd(1, 0); do_cycle();
        check("preg0_hit", 64'(s_hit[1]), 64'd0);
        check("preg0_data", 64'(s_data[1]), 64'd0);

        // Flush
        idle(); wr(0, 7, 32'h33); do_cycle();
        idle(); bus.flush = 1'b1; wr(0, 8, 32'h44); rd(0, 7); do_cycle();
        check("flush_cycle_hit", 64'(s_hit[0]), 64'd1);
        check("flush_cycle_data", 64'(s_data[0]), 64'h33);
        idle(); rd(0, 7); rd(1, 8); do_cycle();
        check("post_flush_7", 64'(s_hit[0]), 64'd0);
        check("post_flush_8", 64'(s_hit[1]), 64'd0);

        // Reset mid-operation
        idle(); wr(0, 12, 32'h5A); do_cycle();
        idle(); rst = 1'b1; rd(0, 12); do_cycle();
        rst = 1'b0;
        idle(); wr(1, 13, 32'h77); rd(0, 12); do_cycle();
        idle(); rd(0, 12); rd(1, 13); do_cycle();
        check("post_rst_old", 64'(s_hit[0]), 64'd0);
        check("post_rst_new_hit", 64'(s_hit[1]), 64'd1);
        check("post_rst_new_data", 64'(s_data[1]), 64'h77);

        // Random streams over a small tag range to force collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            rst       = ($urandom_range(0, 99) < 2);
            bus.flush = ($urandom_range(0, 99) < 5);
            for (int i = 0; i < EU_NUM; i++) begin
                bus.v_wr_en[i]       = ($urandom_range(0, 99) < 60);
                bus.v_wr_preg[i]     = PREG_IDX_W'($urandom_range(0, 15));
                bus.v_wr_reg_data[i] = $urandom;
            end
            for (int i = 0; i < EU_NUM; i++)
                for (int j = i + 1; j < EU_NUM; j++)
                    if (bus.v_wr_en[i] && bus.v_wr_en[j] && bus.v_wr_preg[i] == bus.v_wr_preg[j])
                        bus.v_wr_en[j] = 1'b0;
            for (int p = 0; p < RD_PORT_NUM; p++) begin
                bus.v_rd_en[p]   = ($urandom_range(0, 99) < 80);
                bus.v_rd_preg[p] = PREG_IDX_W'($urandom_range(0, 15));
            end
            do_cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
